// File: rtl/crc_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one CRC datapath between PORTS requesters.
// Grant is held until the last beat handshakes; a watchdog frees a stalled grant.
module crc_rr_arbiter #(
    parameter int unsigned PORTS   = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] req_valid_i,
    input  logic [WIDTH-1:0] req_data_i [PORTS-1:0],
    input  logic [PORTS-1:0] req_last_i,
    output logic [PORTS-1:0] req_ready_o,
    output logic [PORTS-1:0] grant_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t            state_q, state_d;
    logic [PORTS-1:0]  grant_q, grant_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     idle_cnt_q, idle_cnt_d;
    logic [PW-1:0]     winner;
    logic              found;
    int unsigned       scan_idx;

    // Scan starts just after the last served port so it gets lowest priority.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int unsigned i = 1; i <= PORTS; i++) begin
            scan_idx = (int'(ptr_q) + i) % PORTS;
            if (!found && req_valid_i[PW'(scan_idx)]) begin
                found  = 1'b1;
                winner = PW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        idle_cnt_d  = idle_cnt_q;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        req_ready_o = '0;
        timeout_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = LOCK;
                    gidx_d     = winner;
                    grant_d    = PORTS'(1) << winner;
                    idle_cnt_d = '0;
                end
            end
            LOCK: begin
                out_valid_o          = req_valid_i[gidx_q];
                out_data_o           = req_data_i[gidx_q];
                out_last_o           = req_last_i[gidx_q];
                req_ready_o[gidx_q]  = out_ready_i;
                if (out_valid_o && out_ready_i && out_last_o) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    ptr_d      = gidx_q;
                    idle_cnt_d = '0;
                end else if (TIMEOUT > 0 && !req_valid_i[gidx_q]) begin
                    if (idle_cnt_q == CNT_LAST) begin
                        timeout_o  = 1'b1;
                        state_d    = IDLE;
                        grant_d    = '0;
                        ptr_d      = gidx_q;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            ptr_q      <= PW'(PORTS - 1);
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            ptr_q      <= ptr_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == LOCK);

endmodule

// File: tb/tb_crc_rr_arbiter.sv
// Directed self-checking bench for crc_rr_arbiter (PORTS=4, WIDTH=8, TIMEOUT=8).
// Status word: {grant, busy, out_valid, out_last, out_data, req_ready, timeout}.
module tb_crc_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [7:0] req_data [3:0];
    logic [3:0] req_last;
    logic [3:0] req_ready;
    logic [3:0] grant;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic       timeout;

    logic [19:0] obs;
    logic [19:0] exp_v;
    logic [23:0] hs_log;
    int          hs_cnt;
    int          n_checks;
    int          n_fail;

    crc_rr_arbiter #(
        .PORTS   (4),
        .WIDTH   (8),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .grant_o     (grant),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_ready_i (out_ready),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    assign obs = {grant, busy, out_valid, out_last, out_data, req_ready, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic clear_inputs();
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_init: got %b expected %b", obs, exp_v); end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b0100; req_data[2] = 8'h77;
        #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_idle: got %b expected %b", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = {4'b0100, 1'b1, 1'b1, 1'b0, 8'h77, 4'b0100, 1'b0}; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_lock: got %b expected %b", obs, exp_v); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_abort: got %b expected %b", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_hold: got %b expected %b", obs, exp_v); end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_port();
        @(negedge clk);
        req_valid = 4'b0100; req_data[2] = 8'hA1; req_last = 4'b0000; out_ready = 1'b1;
        #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL sp_idle: got %b expected %b", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = {4'b0100, 1'b1, 1'b1, 1'b0, 8'hA1, 4'b0100, 1'b0}; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL sp_beat1: got %b expected %b", obs, exp_v); end
        @(negedge clk);
        req_data[2] = 8'hA2;
        #1;
        exp_v = {4'b0100, 1'b1, 1'b1, 1'b0, 8'hA2, 4'b0100, 1'b0}; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL sp_beat2: got %b expected %b", obs, exp_v); end
        @(negedge clk);
        req_data[2] = 8'hA3; req_last = 4'b0100;
        #1;
        exp_v = {4'b0100, 1'b1, 1'b1, 1'b1, 8'hA3, 4'b0100, 1'b0}; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL sp_beat3: got %b expected %b", obs, exp_v); end
        @(negedge clk);
        clear_inputs();
        #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL sp_release: got %b expected %b", obs, exp_v); end
    endtask

    task automatic test_round_robin();
        int         order [5];
        logic [3:0] oh;
        logic [7:0] d;
        order = '{0, 1, 2, 3, 0};
        do_reset();
        @(negedge clk);
        req_valid = 4'hF; req_last = 4'hF; out_ready = 1'b1;
        for (int p = 0; p < 4; p++) req_data[p] = 8'h10 + 8'(p);
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_v = '0; n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL rr_bubble %0d: got %b expected %b", k, obs, exp_v); end
            @(negedge clk); #1;
            oh = 4'b0001 << order[k];
            d  = 8'h10 + 8'(order[k]);
            exp_v = {oh, 1'b1, 1'b1, 1'b1, d, oh, 1'b0}; n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL rr_grant %0d: got %b expected %b", k, obs, exp_v); end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        hs_cnt = 0; hs_log = '0;
        @(negedge clk);
        req_valid = 4'b0010; req_data[1] = 8'h21; req_last = 4'b0000; out_ready = 1'b1;
        #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL bp_idle: got %b expected %b", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = {4'b0010, 1'b1, 1'b1, 1'b0, 8'h21, 4'b0010, 1'b0}; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL bp_beat1: got %b expected %b", obs, exp_v); end
        if (out_valid && out_ready) begin hs_cnt++; hs_log = {hs_log[15:0], out_data}; end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            req_data[1] = 8'h22; out_ready = 1'b0;
            #1;
            exp_v = {4'b0010, 1'b1, 1'b1, 1'b0, 8'h22, 4'b0000, 1'b0}; n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL bp_stall %0d: got %b expected %b", j, obs, exp_v); end
            if (out_valid && out_ready) begin hs_cnt++; hs_log = {hs_log[15:0], out_data}; end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        exp_v = {4'b0010, 1'b1, 1'b1, 1'b0, 8'h22, 4'b0010, 1'b0}; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL bp_beat2: got %b expected %b", obs, exp_v); end
        if (out_valid && out_ready) begin hs_cnt++; hs_log = {hs_log[15:0], out_data}; end
        @(negedge clk);
        req_data[1] = 8'h23; req_last = 4'b0010;
        #1;
        exp_v = {4'b0010, 1'b1, 1'b1, 1'b1, 8'h23, 4'b0010, 1'b0}; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL bp_beat3: got %b expected %b", obs, exp_v); end
        if (out_valid && out_ready) begin hs_cnt++; hs_log = {hs_log[15:0], out_data}; end
        @(negedge clk);
        clear_inputs();
        #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL bp_release: got %b expected %b", obs, exp_v); end
        n_checks++;
        if (hs_cnt !== 3 || hs_log !== 24'h212223) begin
            n_fail++;
            $display("FAIL bp_beats: got count %0d log %h expected count 3 log 212223", hs_cnt, hs_log);
        end
    endtask

    task automatic test_timeout();
        logic to_exp;
        do_reset();
        @(negedge clk);
        req_valid = 4'b1000; req_data[3] = 8'h31; req_last = 4'b0000; out_ready = 1'b1;
        #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL to_idle: got %b expected %b", obs, exp_v); end
        @(negedge clk);
        req_valid[0] = 1'b1; req_data[0] = 8'h05; req_last[0] = 1'b1;
        #1;
        exp_v = {4'b1000, 1'b1, 1'b1, 1'b0, 8'h31, 4'b1000, 1'b0}; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL to_beat1: got %b expected %b", obs, exp_v); end
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            req_valid[3] = 1'b0;
            #1;
            to_exp = (j == 8);
            exp_v = {4'b1000, 1'b1, 1'b0, 1'b0, 8'h31, 4'b1000, to_exp}; n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL to_idle_cycle %0d: got %b expected %b", j, obs, exp_v); end
        end
        @(negedge clk); #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL to_release: got %b expected %b", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = {4'b0001, 1'b1, 1'b1, 1'b1, 8'h05, 4'b0001, 1'b0}; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL to_next_grant: got %b expected %b", obs, exp_v); end
        @(negedge clk);
        clear_inputs();
        #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL to_done: got %b expected %b", obs, exp_v); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 4'b0001; req_data[0] = 8'h41; req_last = 4'b0000; out_ready = 1'b1;
        #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_idle: got %b expected %b", obs, exp_v); end
        @(negedge clk);
        req_valid[1] = 1'b1; req_data[1] = 8'h51; req_last[1] = 1'b1;
        #1;
        exp_v = {4'b0001, 1'b1, 1'b1, 1'b0, 8'h41, 4'b0001, 1'b0}; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_p0_beat1: got %b expected %b", obs, exp_v); end
        @(negedge clk);
        req_data[0] = 8'h42; req_last[0] = 1'b1;
        #1;
        exp_v = {4'b0001, 1'b1, 1'b1, 1'b1, 8'h42, 4'b0001, 1'b0}; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_p0_beat2: got %b expected %b", obs, exp_v); end
        @(negedge clk);
        req_valid[0] = 1'b0; req_last[0] = 1'b0;
        #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_bubble: got %b expected %b", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = {4'b0010, 1'b1, 1'b1, 1'b1, 8'h51, 4'b0010, 1'b0}; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_p1_grant: got %b expected %b", obs, exp_v); end
        @(negedge clk);
        clear_inputs();
        #1;
        exp_v = '0; n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_done: got %b expected %b", obs, exp_v); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
